// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the iteration-counter width helper.
package mdu_pkg;

    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // Bits needed to count 0..WIDTH/UNROLL-1 (at least one bit).
    function automatic int cnt_width(input int width, input int unroll);
        int n;
        int w;
        n = width / unroll;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One RUN cycle of the datapath: UNROLL chained shift-add (multiply) or
// restoring shift-subtract (divide) cells operating on the {hi, lo} pair.
module mdu_step #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] l;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rsh;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        h   = hi_i;
        l   = lo_i;
        sum = '0;
        rsh = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (is_div_i) begin
                // Partial remainder stays below the divisor, so the W-bit difference is exact.
                rsh = {h, l[WIDTH-1]};
                if (rsh >= {1'b0, m_i}) begin
                    h = rsh[WIDTH-1:0] - m_i;
                    l = {l[WIDTH-2:0], 1'b1};
                end else begin
                    h = rsh[WIDTH-1:0];
                    l = {l[WIDTH-2:0], 1'b0};
                end
            end else begin
                sum = {1'b0, h} + (l[0] ? {1'b0, m_i} : '0);
                h   = sum[WIDTH:1];
                l   = {sum[0], l[WIDTH-1:1]};
            end
        end
        hi_o = h;
        lo_o = l;
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with busy/done handshake driving the
// HiLo write port; magnitudes are iterated, signs restored in FIX.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cancel_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] wHiData,
    output logic [WIDTH-1:0] wLoData,
    output logic             whi,
    output logic             wlo
);

    localparam int N  = WIDTH / UNROLL;
    localparam int CW = cnt_width(WIDTH, UNROLL);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, m_q, hi_q, lo_q;
    logic             neg_lo_q, neg_hi_q, dz_q;
    logic [WIDTH-1:0] res_hi_q, res_lo_q;

    logic             is_div, sa, sb;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign is_div = op_q[1];

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cancel_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (start_i) state_d = S_PREP;
                S_PREP:  state_d = S_RUN;
                S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIX;
                S_FIX:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
        done     = (state_q == S_DONE);
        whi      = done;
        wlo      = done;
        div_zero = done && dz_q;
        wHiData  = res_hi_q;
        wLoData  = res_lo_q;
    end

    // Unsigned ops see their operands as magnitudes with positive sign.
    always_comb begin
        sa    = !op_q[0] && a_q[WIDTH-1];
        sb    = !op_q[0] && m_q[WIDTH-1];
        abs_a = sa ? -a_q : a_q;
        abs_b = sb ? -m_q : m_q;
    end

    mdu_step #(.WIDTH(WIDTH), .UNROLL(UNROLL)) u_step (
        .is_div_i (is_div),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .m_i      (m_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // A zero divisor leaves the dividend in hi after sign restore; only lo needs forcing.
    always_comb begin
        prod_fix = neg_lo_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            fix_hi = neg_hi_q ? -hi_q : hi_q;
            fix_lo = dz_q ? '1 : (neg_lo_q ? -lo_q : lo_q);
        end
    end

    // NOTE: working registers are reloaded on every accepted start, so only results and flags reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_hi_q <= '0;
            res_lo_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (state_q)
                S_IDLE: begin
                    if (state_d == S_PREP) begin
                        op_q <= op_i;
                        a_q  <= opa_i;
                        m_q  <= opb_i;
                    end
                end
                S_PREP: begin
                    hi_q     <= '0;
                    lo_q     <= is_div ? abs_a : abs_b;
                    m_q      <= is_div ? abs_b : abs_a;
                    neg_lo_q <= sa ^ sb;
                    neg_hi_q <= sa;
                    dz_q     <= is_div && (m_q == '0);
                    cnt_q    <= '0;
                end
                S_RUN: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q + CW'(1);
                end
                S_FIX: begin
                    if (state_d == S_DONE) begin
                        res_hi_q <= fix_hi;
                        res_lo_q <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: identical vector set run on a UNROLL=1 and a
// UNROLL=4 instance, with hand-computed results and cycle-exact latency.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic             clk = 1'b0;
    logic [1:0]       rst_v;
    logic [1:0]       start_v;
    logic [1:0]       cancel_v;
    logic [1:0][1:0]  op_v;
    logic [1:0][31:0] opa_v;
    logic [1:0][31:0] opb_v;
    logic [1:0]       busy_v, done_v, dz_v, whi_v, wlo_v;
    logic [1:0][31:0] hi_v, lo_v;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32), .UNROLL(1)) u_dut1 (
        .clk(clk), .rst(rst_v[0]), .start_i(start_v[0]), .cancel_i(cancel_v[0]),
        .op_i(op_v[0]), .opa_i(opa_v[0]), .opb_i(opb_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .div_zero(dz_v[0]),
        .wHiData(hi_v[0]), .wLoData(lo_v[0]), .whi(whi_v[0]), .wlo(wlo_v[0])
    );

    mdu_iter #(.WIDTH(32), .UNROLL(4)) u_dut4 (
        .clk(clk), .rst(rst_v[1]), .start_i(start_v[1]), .cancel_i(cancel_v[1]),
        .op_i(op_v[1]), .opa_i(opa_v[1]), .opb_i(opb_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .div_zero(dz_v[1]),
        .wHiData(hi_v[1]), .wLoData(lo_v[1]), .whi(whi_v[1]), .wlo(wlo_v[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge after the accepting edge (state PREP); operands are then scrambled.
    task automatic launch(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start_v[d] = 1'b1;
        op_v[d]    = op;
        opa_v[d]   = a;
        opb_v[d]   = b;
        @(negedge clk);
        start_v[d] = 1'b0;
        op_v[d]    = ~op;
        opa_v[d]   = ~a;
        opb_v[d]   = b ^ 32'h5A5A_0F0F;
    endtask

    task automatic run_op(input int d, input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int inj_c);
        int n;
        int e;
        int busy_n;
        n      = (d == 0) ? 32 : 8;
        e      = 1;
        busy_n = 0;
        launch(d, op, a, b);
        while (!done_v[d] && e < 200) begin
            if (busy_v[d]) busy_n++;
            if (inj_c >= 0 && e == inj_c + 2) begin
                start_v[d] = 1'b1;
                op_v[d]    = MDU_MULTU;
                opa_v[d]   = 32'h0000_0003;
                opb_v[d]   = 32'h0000_0005;
            end else begin
                start_v[d] = 1'b0;
            end
            @(negedge clk);
            e++;
        end
        start_v[d] = 1'b0;
        check($sformatf("d%0d.%s.latency", d, tag), 64'(e), 64'(n + 3));
        check($sformatf("d%0d.%s.busy_cycles", d, tag), 64'(busy_n), 64'(n + 2));
        check($sformatf("d%0d.%s.busy_at_done", d, tag), 64'(busy_v[d]), 64'(0));
        check($sformatf("d%0d.%s.hi", d, tag), 64'(hi_v[d]), 64'(exp_hi));
        check($sformatf("d%0d.%s.lo", d, tag), 64'(lo_v[d]), 64'(exp_lo));
        check($sformatf("d%0d.%s.div_zero", d, tag), 64'(dz_v[d]), 64'(exp_dz));
        check($sformatf("d%0d.%s.strobes", d, tag), 64'({whi_v[d], wlo_v[d]}), 64'(2'b11));
        @(negedge clk);
        check($sformatf("d%0d.%s.done_pulse", d, tag), 64'({done_v[d], whi_v[d], wlo_v[d]}), 64'(0));
    endtask

    task automatic check_zero(input int d, input string tag);
        check($sformatf("d%0d.%s.ctrl", d, tag),
              64'({busy_v[d], done_v[d], dz_v[d], whi_v[d], wlo_v[d]}), 64'(0));
        check($sformatf("d%0d.%s.hi", d, tag), 64'(hi_v[d]), 64'(0));
        check($sformatf("d%0d.%s.lo", d, tag), 64'(lo_v[d]), 64'(0));
    endtask

    task automatic suite(input int d);
        int n;
        int c;
        int strobes;
        n = (d == 0) ? 32 : 8;
        c = (n - 1 < 10) ? n - 1 : 10;

        run_op(d, "multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, -1);
        run_op(d, "mult_neg",  MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1);
        run_op(d, "div_neg",   MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1);
        run_op(d, "divu",      MDU_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, -1);
        run_op(d, "div_ovf",   MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, -1);
        run_op(d, "divu_zero", MDU_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b1, -1);
        run_op(d, "div_zero_s", MDU_DIV,  32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, -1);
        run_op(d, "start_ign", MDU_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080, 1'b0, 5);

        // Cancel mid-RUN: no completion, held results untouched, then a normal op.
        launch(d, MDU_DIVU, 32'd100, 32'd7);
        repeat (c + 1) @(negedge clk);
        cancel_v[d] = 1'b1;
        @(negedge clk);
        cancel_v[d] = 1'b0;
        check($sformatf("d%0d.cancel.busy", d), 64'(busy_v[d]), 64'(0));
        strobes = 0;
        repeat (n + 6) begin
            if (done_v[d] || whi_v[d] || wlo_v[d]) strobes++;
            @(negedge clk);
        end
        check($sformatf("d%0d.cancel.strobes", d), 64'(strobes), 64'(0));
        check($sformatf("d%0d.cancel.hi_hold", d), 64'(hi_v[d]), 64'(32'h0B00_EA4E));
        check($sformatf("d%0d.cancel.lo_hold", d), 64'(lo_v[d]), 64'(32'h242D_2080));
        run_op(d, "after_cancel", MDU_DIVU, 32'd1000, 32'd33, 32'h0000_000A, 32'h0000_001E, 1'b0, -1);

        // Reset in the middle of RUN wipes outputs at that edge.
        launch(d, MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        rst_v[d] = 1'b0;
        @(negedge clk);
        check_zero(d, "midrun_reset");
        rst_v[d] = 1'b1;
        run_op(d, "after_reset", MDU_MULTU, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, 1'b0, -1);
    endtask

    initial begin
        rst_v    = 2'b00;
        start_v  = '0;
        cancel_v = '0;
        op_v     = '0;
        opa_v    = '0;
        opb_v    = '0;
        repeat (3) @(negedge clk);
        check_zero(0, "reset");
        check_zero(1, "reset");

        // Start requested while reset is held must not be taken.
        start_v = 2'b11;
        @(negedge clk);
        start_v = 2'b00;
        check($sformatf("reset.start_blocked"), 64'(busy_v), 64'(0));
        rst_v = 2'b11;

        // Cancel in IDLE suppresses a same-cycle start.
        @(negedge clk);
        start_v[0]  = 1'b1;
        cancel_v[0] = 1'b1;
        @(negedge clk);
        start_v[0]  = 1'b0;
        cancel_v[0] = 1'b0;
        check("d0.idle_cancel.busy", 64'(busy_v[0]), 64'(0));

        suite(0);
        suite(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
